// File: rtl/golden_nonce_queue.sv
// Golden nonce queue: buffers hits from the hasher control unit until the
// comm block consumes them. Captured nonces are lag-corrected, deduplicated
// against the last accepted value, and dropped (and counted) when full.
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
module golden_nonce_queue #(
    parameter int          DEPTH            = 4,
    parameter logic [31:0] NONCE_CORRECTION = 32'd0
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     new_work,
    input  logic                     rx_golden,
    input  logic [31:0]              rx_nonce,
    output logic                     tx_valid,
    output logic [31:0]              tx_nonce,
    input  logic                     tx_ack,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [15:0]              overflow_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_ovf;
    logic [31:0]   r_last;
    logic          r_last_vld;

    logic [31:0]   w_corr;
    logic          w_dup;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;

    // new_work discards whatever arrives in the same cycle: it belongs to stale work
    assign w_corr     = rx_nonce - NONCE_CORRECTION;
    assign w_dup      = r_last_vld && (w_corr == r_last);
    assign w_full     = (r_count == C_FULL);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !new_work && tx_ack && !w_empty;
    assign w_push_req = !new_work && rx_golden && !w_dup;
    // a simultaneous pop frees the slot, so a full queue still accepts
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Outputs come from registers only; no path from rx_* to any output
    assign tx_valid       = !w_empty;
    assign tx_nonce       = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign tx_count       = r_count;
    assign overflow_count = r_ovf;

    // Entry storage: written on accepted pushes, never reset
    always_ff @(posedge hash_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_corr;
        end
    end

    // Pointers and occupancy; flush on new_work
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (new_work) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Last accepted nonce for duplicate suppression
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (new_work) begin
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= w_corr;
            r_last_vld <= 1'b1;
        end
    end

    // Saturating drop counter; survives new_work
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != 16'hFFFF)) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Bench for golden_nonce_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_golden_nonce_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] CORR  = 32'd2;

    logic        hash_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        new_work = 1'b0;
    logic        rx_golden = 1'b0;
    logic [31:0] rx_nonce = 32'd0;
    logic        tx_valid;
    logic [31:0] tx_nonce;
    logic        tx_ack = 1'b0;
    logic [2:0]  tx_count;
    logic [15:0] overflow_count;

    golden_nonce_queue #(.DEPTH(DEPTH), .NONCE_CORRECTION(CORR)) dut (
        .hash_clk       (hash_clk),
        .reset          (reset),
        .new_work       (new_work),
        .rx_golden      (rx_golden),
        .rx_nonce       (rx_nonce),
        .tx_valid       (tx_valid),
        .tx_nonce       (tx_nonce),
        .tx_ack         (tx_ack),
        .tx_count       (tx_count),
        .overflow_count (overflow_count)
    );

    always #5 hash_clk = ~hash_clk;

    int tests = 0;
    int fails = 0;
    bit run_chk = 1'b0;

    // reference model
    logic [31:0] mq[$];
    logic [31:0] m_last;
    bit          m_lv;
    int          m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lv  = 1'b0;
        m_ovf = 0;
    endtask

    task automatic model_step(input logic g, input logic [31:0] n, input logic a, input logic nw);
        logic [31:0] c;
        bit pop;
        if (nw) begin
            mq.delete();
            m_lv = 1'b0;
        end else begin
            c   = n - CORR;
            pop = a && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (g && !(m_lv && c == m_last)) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(c);
                    m_last = c;
                    m_lv   = 1'b1;
                end else if (m_ovf < 65535) begin
                    m_ovf++;
                end
            end
        end
    endtask

    task automatic cyc(input logic g, input logic [31:0] n, input logic a, input logic nw);
        rx_golden = g; rx_nonce = n; tx_ack = a; new_work = nw;
        @(posedge hash_clk);
        model_step(g, n, a, nw);
        #1;
        rx_golden = 1'b0; tx_ack = 1'b0; new_work = 1'b0;
    endtask

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge hash_clk) begin
        if (!reset && run_chk) begin
            chk("cmp_valid", 32'(tx_valid), 32'(mq.size() != 0));
            chk("cmp_count", 32'(tx_count), 32'(mq.size()));
            chk("cmp_ovf", 32'(overflow_count), 32'(m_ovf));
            if (mq.size() != 0) chk("cmp_nonce", tx_nonce, mq[0]);
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_count", 32'(tx_count), 32'd0);
        chk("rst_ovf", 32'(overflow_count), 32'd0);
        chk("rst_nonce", tx_nonce, 32'd0);
        @(negedge hash_clk); #2;
        reset = 1'b0;
        run_chk = 1'b1;

        // single hit with correction, then ack
        cyc(1, 32'h0000_1234, 0, 0);
        chk("hit_valid", 32'(tx_valid), 32'd1);
        chk("hit_nonce", tx_nonce, 32'h0000_1232);
        chk("hit_count", 32'(tx_count), 32'd1);
        cyc(0, 0, 1, 0);
        chk("hit_acked", 32'(tx_valid), 32'd0);
        cyc(0, 0, 1, 0);  // ack while empty: ignored
        chk("ack_empty", 32'(tx_count), 32'd0);

        // overflow: six distinct pushes into DEPTH=4
        for (int i = 0; i < 6; i++) cyc(1, 32'd100 + 32'(i), 0, 0);
        chk("ovf_count", 32'(tx_count), 32'd4);
        chk("ovf_ovf", 32'(overflow_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", tx_nonce, 32'd98 + 32'(i));
            cyc(0, 0, 1, 0);
        end
        chk("ovf_drained", 32'(tx_valid), 32'd0);

        // full queue, push with simultaneous pop
        for (int i = 0; i < 4; i++) cyc(1, 32'd200 + 32'(i), 0, 0);
        cyc(1, 32'd300, 1, 0);
        chk("pp_count", 32'(tx_count), 32'd4);
        chk("pp_ovf", 32'(overflow_count), 32'd2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        chk("pp_last", tx_nonce, 32'd298);
        cyc(0, 0, 1, 0);

        // dedup: corrected 5,5,6
        cyc(1, 32'd7, 0, 0);
        cyc(1, 32'd7, 0, 0);
        cyc(1, 32'd8, 0, 0);
        chk("dd_count", 32'(tx_count), 32'd2);
        chk("dd_ovf", 32'(overflow_count), 32'd2);
        chk("dd_head", tx_nonce, 32'd5);
        cyc(0, 0, 1, 0);
        chk("dd_second", tx_nonce, 32'd6);
        cyc(0, 0, 1, 0);

        // wrap: one resident entry plus 10 push/pop pairs
        cyc(1, 32'd1000, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 32'd1001 + 32'(i), 1, 0);
        chk("wrap_count", 32'(tx_count), 32'd1);
        chk("wrap_head", tx_nonce, 32'd1008);
        cyc(0, 0, 1, 0);

        // flush with simultaneous push
        for (int i = 0; i < 3; i++) cyc(1, 32'd50 + 32'(i), 0, 0);
        cyc(1, 32'd60, 1, 1);
        chk("fl_count", 32'(tx_count), 32'd0);
        chk("fl_valid", 32'(tx_valid), 32'd0);
        chk("fl_ovf", 32'(overflow_count), 32'd2);
        cyc(1, 32'd52, 0, 0);  // same as last accepted before flush: not a dup now
        chk("fl_dedup_clr", 32'(tx_count), 32'd1);
        chk("fl_dedup_val", tx_nonce, 32'd50);
        cyc(0, 0, 1, 0);

        // async reset mid-cycle with 2 entries
        cyc(1, 32'd70, 0, 0);
        cyc(1, 32'd71, 0, 0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("ar_valid", 32'(tx_valid), 32'd0);
        chk("ar_count", 32'(tx_count), 32'd0);
        chk("ar_ovf", 32'(overflow_count), 32'd0);
        @(posedge hash_clk);
        @(negedge hash_clk); #2;
        reset = 1'b0;
        cyc(1, 32'd71, 0, 0);  // last-accepted invalid after reset
        chk("ar_first", 32'(tx_count), 32'd1);
        chk("ar_first_val", tx_nonce, 32'd69);

        // random traffic: small nonce space to hit dedup, some overflow
        for (int i = 0; i < 600; i++) begin
            cyc(logic'($urandom_range(0, 99) < 55),
                32'($urandom_range(0, 7)),
                logic'($urandom_range(0, 99) < 35),
                logic'($urandom_range(0, 99) < 3));
        end

        @(negedge hash_clk);
        #1;
        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
